pp_preprocess_mc: RTL and testbench
===================================

Name: pp_preprocess_mc

Overview:
Parametrised successor to the camera-side preprocessing stage. It pulls pixels from the capture FIFO and applies one of four colour modes: passthrough, greyscale, binary threshold or inverted greyscale. Results are buffered in an internal output FIFO that carries an end-of-line tag with each pixel. It sits between the capture FIFO and the row-burst consumers (Gaussian/filter chain). Unlike the previous stage it adds credit-based backpressure, frame-aligned mode switching, line/frame counting and a row-ready flag.

Parameters:
DATA_W, 12, pixel width; three equal channels of CH_W = DATA_W/3 (R msb, B lsb); must be a multiple of 3.
LINE_W, 640, pixels per line; sets EOL tag and row-ready threshold.
FRAME_H, 480, lines per frame; sets the frame boundary for the mode switch.
ADDR_W, 10, output FIFO depth = 2^ADDR_W; must satisfy 2^ADDR_W >= LINE_W.
AE_OFFSET, 2, o_almostempty asserted when fill <= AE_OFFSET.

Ports:
i_clk  in  1  clock; single clock domain
i_rstn  in  1  reset; asynchronous assert, active-low
i_flush  in  1  sync flush; clears FIFO, pipeline, counters
i_mode  in  2  0 passthrough, 1 greyscale, 2 threshold, 3 inverted greyscale
i_thresh  in  CH_W  threshold for mode 2
o_rd  out  1  capture FIFO read enable (registered)
i_data  in  DATA_W  capture FIFO data, valid the cycle after o_rd
i_almostempty  in  1  capture FIFO almost-empty
i_rd  in  1  output FIFO read enable
o_data  out  DATA_W  output pixel
o_eol  out  1  o_data is the last pixel of a line
o_valid  out  1  o_data/o_eol valid
o_fill  out  ADDR_W+1  output FIFO occupancy
o_almostempty  out  1  fill <= AE_OFFSET
o_row_ready  out  1  fill >= LINE_W
o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is written

Behaviour:
- Reset (async, i_rstn=0): o_rd=0, o_valid=0, o_eol=0, o_data=0, o_fill=0, o_almostempty=1, o_row_ready=0, o_frame_done=0. Counters, inflight and pipeline valids are 0. mode_q loads i_mode.
- Read FSM: IDLE/ACTIVE.
  - IDLE->ACTIVE when !i_almostempty && credit_ok. o_rd then registers to 1.
  - ACTIVE->IDLE when i_almostempty || !credit_ok || i_flush.
  - credit_ok = (o_fill + inflight + 1) < 2^ADDR_W. inflight counts pixels read but not yet written; max 3.
  - Result: the FIFO never overflows and a pixel is never dropped.
- Input capture: din_valid = o_rd delayed 1 cycle; i_data is sampled in that cycle.
- Pipeline: 2 stages; all modes have identical latency so order is preserved.
  - S1 computes grey = (5R + 9G + 2B) >> 4. The sum is CH_W+4 bits; the result is CH_W bits and never saturates.
  - S2 applies mode_q:
    - mode 0: data unchanged.
    - mode 1: {grey,grey,grey}.
    - mode 2: all ones if grey >= i_thresh, else 0.
    - mode 3: {~grey,~grey,~grey}.
- Latency: from din_valid to the FIFO write is 2 cycles, so data is visible in o_fill 3 cycles after din_valid.
- Counters: col and row advance on each FIFO write.
  - eol = (col == LINE_W-1). At eol, col wraps to 0 and row increments.
  - When row == FRAME_H-1 and eol: row wraps to 0, o_frame_done pulses, and mode_q loads i_mode. mode_q takes effect from the next written pixel.
  - i_mode changes mid-frame have no effect until the frame boundary.
- Output FIFO: DATA_W+1 bits wide (data plus eol).
  - i_rd when not empty: o_valid=1 next cycle, with the registered o_data/o_eol.
  - i_rd when empty: ignored, o_valid=0.
  - Simultaneous write and read: fill unchanged. A write to an empty FIFO is readable the following cycle.
- Flush (i_flush=1, synchronous, highest priority after reset):
  - Empties the FIFO and zeroes col, row, inflight and pipeline valids.
  - Sets o_rd=0 and o_valid=0; mode_q loads i_mode.
  - Any i_data returning in the cycle after the flush is discarded.
  - Reads resume at the earliest one cycle after i_flush deasserts.
- Reset mid-operation: asynchronous clear to the reset values; no partial writes.

Test Plan:
- Passthrough: DATA_W=12, mode 0, feed 12'hF00, 12'h0F0, 12'h00F, 12'hFFF -> read back identical values in order; o_rd first asserts 1 cycle after i_almostempty falls.
- Greyscale: mode 1, inputs F00/0F0/00F/FFF -> 444/888/111/FFF. Mode 3 with the same inputs -> BBB/777/EEE/000.
- Threshold: mode 2, i_thresh=8 -> F00 gives 000, 0F0 gives FFF; i_thresh=9 -> 0F0 gives 000.
- Line/frame: LINE_W=4, FRAME_H=2, 8 pixels -> o_eol on pixels 3 and 7; o_row_ready rises when fill reaches 4; o_frame_done pulses once, on the write of pixel 7. Switch i_mode 0->1 at pixel 2 -> pixels 0-7 pass through, pixel 8 onward is grey.
- Backpressure: ADDR_W=3, i_rd held 0, source never empty -> fill saturates at 8, never more; no write while full. Then read all 8 -> consecutive values, none lost or duplicated.
- Flush/reset: assert i_flush while o_rd=1 with 3 pixels inflight -> next cycle fill=0, o_valid=0, subsequently fed pixel has col=0. Async i_rstn low mid-burst -> all outputs reach their reset values without a clock edge.

Source files
------------

// File: rtl/pp_preprocess_mc.sv
// Colour-mode preprocessing stage between the capture FIFO and the row-burst
// consumers. Pulls pixels under a credit limit, converts them through a
// two-stage pipeline and buffers them with an end-of-line tag in an output
// FIFO. Mode changes are latched only at frame boundaries.
module pp_preprocess_mc #(
    parameter int DATA_W    = 12,
    parameter int LINE_W    = 640,
    parameter int FRAME_H   = 480,
    parameter int ADDR_W    = 10,
    parameter int AE_OFFSET = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic [1:0]            i_mode,
    input  logic [DATA_W/3-1:0]   i_thresh,
    output logic                  o_rd,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_almostempty,
    input  logic                  i_rd,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_eol,
    output logic                  o_valid,
    output logic [ADDR_W:0]       o_fill,
    output logic                  o_almostempty,
    output logic                  o_row_ready,
    output logic                  o_frame_done
);

    localparam int CH_W  = DATA_W / 3;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = (COL_W)'(LINE_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = (ROW_W)'(FRAME_H - 1);
    localparam logic [ADDR_W+1:0] DEPTH_V  = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   AE_V     = (ADDR_W+1)'(AE_OFFSET);
    localparam logic [ADDR_W:0]   LINE_V   = (ADDR_W+1)'(LINE_W);

    typedef enum logic {IDLE, ACTIVE} rd_state_t;

    // Weighted luma (5R + 9G + 2B) / 16; weights sum to 16 so it never saturates.
    function automatic logic [CH_W-1:0] grey_of(input logic [DATA_W-1:0] px);
        logic [CH_W+3:0] r4, g4, b4, sum;
        r4  = (CH_W+4)'(px[3*CH_W-1:2*CH_W]);
        g4  = (CH_W+4)'(px[2*CH_W-1:CH_W]);
        b4  = (CH_W+4)'(px[CH_W-1:0]);
        sum = (r4 << 2) + r4 + (g4 << 3) + g4 + (b4 << 1);
        return sum[CH_W+3:4];
    endfunction

    function automatic logic [DATA_W-1:0] apply_mode(input logic [DATA_W-1:0] px,
                                                    input logic [CH_W-1:0]   grey,
                                                    input logic [1:0]        mode,
                                                    input logic [CH_W-1:0]   thresh);
        logic [DATA_W-1:0] res;
        case (mode)
            2'd0:    res = px;
            2'd1:    res = {3{grey}};
            2'd2:    res = (grey >= thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default: res = {3{~grey}};
        endcase
        return res;
    endfunction

    rd_state_t         state;
    logic              dv_p0, vld_p1, vld_p2;
    logic [DATA_W-1:0] data_p1, data_p2;
    logic [CH_W-1:0]   grey_p1, grey_p2;
    logic [1:0]        mode_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   fill;
    logic [DATA_W:0]   mem [DEPTH];

    logic [1:0]        inflight;
    logic [ADDR_W+1:0] credit_need;
    logic              credit_ok;
    logic              wr_en, rd_en, eol;
    logic [DATA_W:0]   wr_word;

    // A pixel is inflight from its data cycle until the FIFO write; the read
    // being issued this cycle is covered by the +1 headroom in the credit test.
    assign inflight    = {1'b0, dv_p0} + {1'b0, vld_p1} + {1'b0, vld_p2};
    assign credit_need = {1'b0, fill} + {{ADDR_W{1'b0}}, inflight} + 1'b1;
    assign credit_ok   = credit_need < DEPTH_V;

    assign wr_en   = vld_p2;
    assign rd_en   = i_rd && (fill != '0);
    assign eol     = (col == COL_LAST);
    assign wr_word = {eol, apply_mode(data_p2, grey_p2, mode_q, i_thresh)};

    assign o_fill        = fill;
    assign o_almostempty = (fill <= AE_V);
    assign o_row_ready   = (fill >= LINE_V);

    // Read-request FSM: issue capture-FIFO reads while data and credit exist.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            o_rd  <= 1'b0;
        end else if (i_flush) begin
            state <= IDLE;
            o_rd  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_almostempty && credit_ok) begin
                        state <= ACTIVE;
                        o_rd  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (i_almostempty || !credit_ok) begin
                        state <= IDLE;
                        o_rd  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_rd  <= 1'b0;
                end
            endcase
        end
    end

    // Valid chain: data-return cycle (p0), luma stage (p1), mode stage (p2).
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dv_p0  <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (i_flush) begin
            dv_p0  <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            dv_p0  <= o_rd;
            vld_p1 <= dv_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Pipeline data: capture pixel and luma, then hold both for the mode stage.
    always_ff @(posedge i_clk) begin
        data_p1 <= i_data;
        grey_p1 <= grey_of(i_data);
        data_p2 <= data_p1;
        grey_p2 <= grey_p1;
    end

    // Column/row position of the next write; mode latches at frame end.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col          <= '0;
            row          <= '0;
            mode_q       <= i_mode;
            o_frame_done <= 1'b0;
        end else if (i_flush) begin
            col          <= '0;
            row          <= '0;
            mode_q       <= i_mode;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (wr_en) begin
                if (eol) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row          <= '0;
                        o_frame_done <= 1'b1;
                        mode_q       <= i_mode;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Output FIFO storage.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_flush) mem[wr_ptr] <= wr_word;
    end

    // Registered read port.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_eol   <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_en;
            if (rd_en) {o_eol, o_data} <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_pp_preprocess_mc.sv
// Randomised bench for pp_preprocess_mc with a small-line, small-FIFO
// configuration and a frame/index-based reference model of the output stream.
module tb_pp_preprocess_mc;

    localparam int DATA_W    = 12;
    localparam int LINE_W    = 4;
    localparam int FRAME_H   = 2;
    localparam int ADDR_W    = 3;
    localparam int AE_OFFSET = 2;
    localparam int FPIX      = LINE_W * FRAME_H;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_flush;
    logic [1:0]        i_mode;
    logic [3:0]        i_thresh;
    logic              o_rd;
    logic [11:0]       i_data;
    logic              i_almostempty;
    logic              i_rd;
    logic [11:0]       o_data;
    logic              o_eol;
    logic              o_valid;
    logic [ADDR_W:0]   o_fill;
    logic              o_almostempty;
    logic              o_row_ready;
    logic              o_frame_done;

    always #5 i_clk = ~i_clk;

    pp_preprocess_mc #(
        .DATA_W(DATA_W), .LINE_W(LINE_W), .FRAME_H(FRAME_H),
        .ADDR_W(ADDR_W), .AE_OFFSET(AE_OFFSET)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_mode(i_mode),
        .i_thresh(i_thresh), .o_rd(o_rd), .i_data(i_data),
        .i_almostempty(i_almostempty), .i_rd(i_rd), .o_data(o_data),
        .o_eol(o_eol), .o_valid(o_valid), .o_fill(o_fill),
        .o_almostempty(o_almostempty), .o_row_ready(o_row_ready),
        .o_frame_done(o_frame_done)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference state: pixels accepted since the last flush, in read order.
    logic [11:0] acc[$];
    logic [11:0] src_q[$];
    int          chg_n[$];
    int          chg_mode[$];
    int          chg_thr[$];
    int          init_mode, init_thr;
    int          rd_idx    = 0;
    int          cyc       = 0;
    int          flush_cyc = -10;
    bit          rd_prev   = 1'b0;
    int          fd_cnt    = 0;
    int          max_fill  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {eol, data} of the k-th pixel written since the last flush.
    function automatic logic [12:0] model_out(input int k);
        int f, md, thr, r, g, b, gr;
        logic [11:0] p, res;
        p   = acc[k];
        f   = k / FPIX;
        md  = init_mode;
        thr = init_thr;
        foreach (chg_n[i]) begin
            if (f > 0 && chg_n[i] <= f * FPIX - 1) md = chg_mode[i];
            if (chg_n[i] <= k) thr = chg_thr[i];
        end
        r  = int'(p[11:8]);
        g  = int'(p[7:4]);
        b  = int'(p[3:0]);
        gr = (5 * r + 9 * g + 2 * b) / 16;
        case (md)
            0:       res = p;
            1:       res = {gr[3:0], gr[3:0], gr[3:0]};
            2:       res = (gr >= thr) ? 12'hFFF : 12'h000;
            default: res = {3{4'(15 - gr)}};
        endcase
        return {((k % LINE_W) == LINE_W - 1), res};
    endfunction

    function automatic logic [11:0] next_src();
        if (src_q.size() > 0) return src_q.pop_front();
        return 12'($urandom);
    endfunction

    // One clock: source answers last cycle's read, output stream is checked.
    task automatic step();
        logic [11:0] v;
        logic [12:0] e;
        @(posedge i_clk);
        #1;
        cyc++;
        if (rd_prev) begin
            v = next_src();
            i_data = v;
            if (cyc > flush_cyc + 1) acc.push_back(v);
        end else begin
            i_data = 12'($urandom);
        end
        rd_prev = o_rd;
        if (o_valid) begin
            if (rd_idx < acc.size()) begin
                e = model_out(rd_idx);
                check("pix_data", 32'(o_data), 32'(e[11:0]));
                check("pix_eol", 32'(o_eol), 32'(e[12]));
                rd_idx++;
            end else begin
                check("spurious_valid", 32'(o_valid), 32'(0));
            end
        end
        if (o_frame_done) fd_cnt++;
        if (int'(o_fill) > max_fill) max_fill = int'(o_fill);
    endtask

    task automatic settle();
        i_almostempty = 1'b1;
        i_rd = 1'b0;
        repeat (8) step();
    endtask

    task automatic quiet_check(input string tag);
        int mf;
        settle();
        mf = acc.size() - rd_idx;
        check({tag, "_fill"}, 32'(o_fill), 32'(mf));
        check({tag, "_ae"}, 32'(o_almostempty), 32'(mf <= AE_OFFSET));
        check({tag, "_rowrdy"}, 32'(o_row_ready), 32'(mf >= LINE_W));
        check({tag, "_frames"}, 32'(fd_cnt), 32'(acc.size() / FPIX));
    endtask

    task automatic feed(input int n, input int rdp);
        for (int i = 0; i < n; i++) begin
            i_almostempty = 1'b0;
            i_rd = ($urandom_range(99) < rdp);
            step();
        end
        settle();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (rd_idx < acc.size() && g < 100) begin
            i_rd = 1'b1;
            step();
            g++;
        end
        i_rd = 1'b0;
        step();
        check("drain_all", 32'(rd_idx), 32'(acc.size()));
    endtask

    task automatic do_flush(input bit rd);
        i_flush = 1'b1;
        i_rd = rd;
        acc.delete();
        chg_n.delete();
        chg_mode.delete();
        chg_thr.delete();
        rd_idx    = 0;
        init_mode = int'(i_mode);
        init_thr  = int'(i_thresh);
        fd_cnt    = 0;
        flush_cyc = cyc;
        step();
        i_flush = 1'b0;
        i_rd = 1'b0;
    endtask

    task automatic flush_to(input int m, input int t);
        i_mode = 2'(m);
        i_thresh = 4'(t);
        do_flush(1'b0);
        settle();
    endtask

    task automatic set_mode(input int m, input int t);
        i_mode = 2'(m);
        i_thresh = 4'(t);
        chg_n.push_back(acc.size());
        chg_mode.push_back(m);
        chg_thr.push_back(t);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"}, 32'(o_rd), 32'(0));
        check({tag, "_valid"}, 32'(o_valid), 32'(0));
        check({tag, "_eol"}, 32'(o_eol), 32'(0));
        check({tag, "_data"}, 32'(o_data), 32'(0));
        check({tag, "_fill"}, 32'(o_fill), 32'(0));
        check({tag, "_ae"}, 32'(o_almostempty), 32'(1));
        check({tag, "_rowrdy"}, 32'(o_row_ready), 32'(0));
        check({tag, "_fdone"}, 32'(o_frame_done), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0;
        i_flush = 1'b0;
        i_mode = 2'd0;
        i_thresh = 4'd8;
        i_almostempty = 1'b1;
        i_rd = 1'b0;
        i_data = '0;
        init_mode = 0;
        init_thr = 8;
        #1;
        check_reset_values("reset");
        repeat (3) step();
        i_rstn = 1'b1;
        repeat (3) step();
        check("rd_idle", 32'(o_rd), 32'(0));

        // Passthrough; read request one cycle after almost-empty falls.
        src_q = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        i_almostempty = 1'b0;
        step();
        check("rd_start", 32'(o_rd), 32'(1));
        repeat (3) step();
        quiet_check("pass");
        drain();

        // Greyscale and inverted greyscale.
        flush_to(1, 8);
        src_q = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        feed(4, 0);
        quiet_check("grey");
        drain();
        flush_to(3, 8);
        src_q = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        feed(4, 0);
        drain();

        // Threshold with a mid-line threshold change.
        flush_to(2, 8);
        src_q = '{12'hF00, 12'h0F0};
        feed(2, 0);
        set_mode(2, 9);
        src_q = '{12'h0F0};
        feed(1, 0);
        drain();

        // Line/frame tagging with a mode request in the middle of frame 0.
        flush_to(0, 8);
        feed(2, 0);
        set_mode(1, 8);
        feed(6, 0);
        quiet_check("frame");
        drain();
        feed(4, 0);
        drain();

        // Backpressure: no reads, source always available.
        flush_to(0, 8);
        max_fill = 0;
        feed(30, 0);
        quiet_check("bp");
        check("bp_fill8", 32'(o_fill), 32'(8));
        check("bp_maxfill", 32'(max_fill), 32'(8));
        drain();

        // Flush in the middle of a burst with reads in flight.
        flush_to(0, 8);
        feed(3, 0);
        i_almostempty = 1'b0;
        repeat (5) step();
        check("fl_pre_rd", 32'(o_rd), 32'(1));
        i_almostempty = 1'b1;
        do_flush(1'b1);
        check("fl_fill", 32'(o_fill), 32'(0));
        check("fl_valid", 32'(o_valid), 32'(0));
        settle();
        src_q = '{12'h123, 12'h456, 12'h789, 12'hABC};
        feed(4, 0);
        quiet_check("postfl");
        drain();

        // Random traffic: mode/threshold changes, flushes, concurrent reads.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(9);
            if (r == 0) flush_to($urandom_range(3), $urandom_range(15));
            else if (r < 4) set_mode($urandom_range(3), $urandom_range(15));
            feed($urandom_range(1, 20), $urandom_range(0, 100));
            if ($urandom_range(2) == 0) quiet_check("rnd");
            if ($urandom_range(1) == 0) drain();
        end
        drain();

        // Asynchronous reset in the middle of a burst.
        i_almostempty = 1'b0;
        i_rd = 1'b1;
        repeat (6) step();
        #3;
        i_rstn = 1'b0;
        #1;
        check_reset_values("areset");
        #20;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
